// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display_ctrl
//  Description : Registered multi-digit hex seven-segment controller with
//                leading-zero suppression, per-digit blink and static or
//                time-multiplexed output buses.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl #(
    parameter int DIGITS     = 8,
    parameter int SCAN_BITS  = 16,
    parameter int BLINK_BITS = 24,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    input  logic                  mux_mode,
    output logic [7*DIGITS-1:0]   seg_static,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int                  c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(DIGITS - 1);
    localparam logic [6:0]          c_SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0]   c_SEL_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0]  r_held;
    logic [SCAN_BITS-1:0] r_pre;
    logic [c_IDX_W-1:0]   r_idx;
    logic [BLINK_BITS-1:0] r_blink;
    logic [7*DIGITS-1:0]  r_seg_static;
    logic [6:0]           r_seg_mux;
    logic [DIGITS-1:0]    r_dig_sel;

    logic [DIGITS-1:0]    w_zero;
    logic [DIGITS-1:0]    w_lz_run;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_acc;
    logic [7*DIGITS-1:0]  w_static;
    logic [6:0]           w_mux_seg;
    logic [DIGITS-1:0]    w_onehot;
    logic                 w_blink_phase;

    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_blink_phase = r_blink[BLINK_BITS-1];

    // w_lz_run[i] is set when digit i and every digit above it hold zero.
    always_comb begin
        w_lz_run = '0;
        w_acc    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_acc       = w_acc & w_zero[i];
            w_lz_run[i] = w_acc;
        end
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_zero[i] = (r_held[4*i +: 4] == 4'h0);
            if (i == 0) begin : g_lsd
                // The least significant digit is never suppressed.
                assign w_blank[i] = blink_mask[i] & w_blink_phase;
            end else begin : g_upper
                assign w_blank[i] = (blank_lz & w_lz_run[i]) |
                                    (blink_mask[i] & w_blink_phase);
            end
            assign w_static[7*i +: 7] = w_blank[i] ? 7'h00 : f_hex_to_seg(r_held[4*i +: 4]);
        end
    endgenerate

    always_comb begin
        w_mux_seg = 7'h00;
        w_onehot  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_mux_seg   = w_static[7*i +: 7];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_held       <= '0;
            r_pre        <= '0;
            r_idx        <= '0;
            r_blink      <= '0;
            r_seg_static <= {DIGITS{c_SEG_OFF}};
            r_seg_mux    <= c_SEG_OFF;
            r_dig_sel    <= c_SEL_OFF;
        end else begin
            if (load) begin
                r_held <= value;
            end
            r_blink <= r_blink + BLINK_BITS'(1);

            // Counters sit at zero outside mux mode so a new scan starts on digit 0.
            if (mux_mode) begin
                r_pre <= r_pre + SCAN_BITS'(1);
                if (&r_pre) begin
                    r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
                end
            end else begin
                r_pre <= '0;
                r_idx <= '0;
            end

            r_seg_static <= w_static ^ {DIGITS{c_SEG_OFF}};
            r_seg_mux    <= mux_mode ? (w_mux_seg ^ c_SEG_OFF) : c_SEG_OFF;
            r_dig_sel    <= mux_mode ? (w_onehot ^ c_SEL_OFF) : c_SEL_OFF;
        end
    end

    assign seg_static = r_seg_static;
    assign seg_mux    = r_seg_mux;
    assign dig_sel    = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display_ctrl
//  Description : Directed self-checking bench for seg7_display_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_ctrl;

    logic        clk;
    logic        reset_in;
    logic [31:0] value;
    logic        load;
    logic [7:0]  blink_mask;
    logic        blank_lz;
    logic        mux_mode;

    logic [55:0] seg_static_a, seg_static_b;
    logic [6:0]  seg_mux_a, seg_mux_b, seg_mux_c;
    logic [7:0]  dig_sel_a, dig_sel_b;
    logic [6:0]  seg_static_c;
    logic [0:0]  dig_sel_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tbl [16];

    seg7_display_ctrl #(.DIGITS(8), .SCAN_BITS(2), .BLINK_BITS(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .reset_in(reset_in), .value(value), .load(load),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .mux_mode(mux_mode),
        .seg_static(seg_static_a), .seg_mux(seg_mux_a), .dig_sel(dig_sel_a)
    );

    seg7_display_ctrl #(.DIGITS(8), .SCAN_BITS(2), .BLINK_BITS(4), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset_in(reset_in), .value(value), .load(load),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .mux_mode(mux_mode),
        .seg_static(seg_static_b), .seg_mux(seg_mux_b), .dig_sel(dig_sel_b)
    );

    seg7_display_ctrl #(.DIGITS(1), .SCAN_BITS(2), .BLINK_BITS(4), .ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .reset_in(reset_in), .value(value[3:0]), .load(load),
        .blink_mask(blink_mask[0]), .blank_lz(blank_lz), .mux_mode(mux_mode),
        .seg_static(seg_static_c), .seg_mux(seg_mux_c), .dig_sel(dig_sel_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [55:0] exp;
        reset_in = 1'b1;
        load     = 1'b1;
        value    = 32'hFFFF_FFFF;
        step();
        step();
        if (seg_static_a !== 56'h0) begin n_fail++; $display("FAIL reset_static_a: got %h expected %h", seg_static_a, 56'h0); end
        n_checks++;
        if ({seg_mux_a, dig_sel_a} !== 15'h0) begin n_fail++; $display("FAIL reset_mux_a: got %h/%h expected 00/00", seg_mux_a, dig_sel_a); end
        n_checks++;
        if (seg_static_b !== {56{1'b1}}) begin n_fail++; $display("FAIL reset_static_b: got %h expected all ones", seg_static_b); end
        n_checks++;
        if (seg_mux_b !== 7'h7F || dig_sel_b !== 8'hFF) begin n_fail++; $display("FAIL reset_mux_b: got %h/%h expected 7f/ff", seg_mux_b, dig_sel_b); end
        n_checks++;
        reset_in = 1'b0;
        load     = 1'b0;
        step();
        exp = {8{7'h3F}};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL reset_over_load_a: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        exp = {8{7'h40}};
        if (seg_static_b !== exp) begin n_fail++; $display("FAIL reset_over_load_b: got %h expected %h", seg_static_b, exp); end
        n_checks++;
    endtask

    task automatic test_load();
        logic [55:0] exp;
        value = 32'h0000_00A5;
        load  = 1'b1;
        step();
        load = 1'b0;
        exp = {8{7'h3F}};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL load_latency: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        step();
        exp = {{6{7'h3F}}, 7'h77, 7'h6D};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL load_a5: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        blank_lz = 1'b1;
        step();
        exp = {{6{7'h00}}, 7'h77, 7'h6D};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL lz_a5: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        value = 32'h0;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        exp = {{7{7'h00}}, 7'h3F};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL lz_zero: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        value = 32'h0030_0000;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        exp = {{2{7'h00}}, 7'h4F, {5{7'h3F}}};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL lz_inner_zero: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        blank_lz = 1'b0;
    endtask

    task automatic test_active_low();
        logic [55:0] exp;
        value = 32'h8888_8888;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        if (seg_static_b !== 56'h0) begin n_fail++; $display("FAIL active_low_8s: got %h expected %h", seg_static_b, 56'h0); end
        n_checks++;
        exp = {8{7'h7F}};
        if (seg_static_a !== exp) begin n_fail++; $display("FAIL active_high_8s: got %h expected %h", seg_static_a, exp); end
        n_checks++;
        if (seg_mux_b !== 7'h7F || dig_sel_b !== 8'hFF) begin n_fail++; $display("FAIL active_low_idle_mux: got %h/%h expected 7f/ff", seg_mux_b, dig_sel_b); end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        value = 32'h1111_1111;
        load  = 1'b1;
        step();
        value = 32'h2222_2222;
        step();
        load = 1'b0;
        if (seg_static_a[6:0] !== 7'h06) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", seg_static_a[6:0], 7'h06); end
        n_checks++;
        step();
        if (seg_static_a[6:0] !== 7'h5B) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", seg_static_a[6:0], 7'h5B); end
        n_checks++;
    endtask

    task automatic test_blink();
        logic [6:0]  exp0;
        logic [48:0] exp_hi;
        reset_in = 1'b1;
        step();
        reset_in   = 1'b0;
        load       = 1'b1;
        value      = 32'h0000_0001;
        blink_mask = 8'h01;
        step();
        load   = 1'b0;
        exp_hi = {7{7'h3F}};
        for (int n = 2; n <= 24; n++) begin
            step();
            exp0 = (((n - 1) % 16) >= 8) ? 7'h00 : 7'h06;
            if (seg_static_a[6:0] !== exp0) begin n_fail++; $display("FAIL blink_d0 edge %0d: got %h expected %h", n, seg_static_a[6:0], exp0); end
            n_checks++;
            if (seg_static_a[55:7] !== exp_hi) begin n_fail++; $display("FAIL blink_others edge %0d: got %h expected %h", n, seg_static_a[55:7], exp_hi); end
            n_checks++;
        end
        blink_mask = 8'h00;
    endtask

    task automatic test_mux();
        int         idx;
        logic [7:0] exp_sel;
        value = 32'h7654_3210;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        if (dig_sel_a !== 8'h00 || seg_mux_a !== 7'h00) begin n_fail++; $display("FAIL static_idle_mux: got %h/%h expected 00/00", seg_mux_a, dig_sel_a); end
        n_checks++;
        mux_mode = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            step();
            idx     = ((n - 1) / 4) % 8;
            exp_sel = 8'(1 << idx);
            if (dig_sel_a !== exp_sel) begin n_fail++; $display("FAIL mux_sel edge %0d: got %h expected %h", n, dig_sel_a, exp_sel); end
            n_checks++;
            if (seg_mux_a !== seg_tbl[idx]) begin n_fail++; $display("FAIL mux_seg edge %0d: got %h expected %h", n, seg_mux_a, seg_tbl[idx]); end
            n_checks++;
            if (dig_sel_b !== ~exp_sel) begin n_fail++; $display("FAIL mux_sel_b edge %0d: got %h expected %h", n, dig_sel_b, ~exp_sel); end
            n_checks++;
            if (dig_sel_c !== 1'b1) begin n_fail++; $display("FAIL mux_sel_single edge %0d: got %h expected 1", n, dig_sel_c); end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid_dwell();
        int         idx;
        logic [7:0] exp_sel;
        step();
        step();
        reset_in = 1'b1;
        step();
        if (dig_sel_a !== 8'h00 || seg_mux_a !== 7'h00) begin n_fail++; $display("FAIL mid_reset_a: got %h/%h expected 00/00", seg_mux_a, dig_sel_a); end
        n_checks++;
        if (dig_sel_b !== 8'hFF || seg_mux_b !== 7'h7F) begin n_fail++; $display("FAIL mid_reset_b: got %h/%h expected 7f/ff", seg_mux_b, dig_sel_b); end
        n_checks++;
        reset_in = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            idx     = (n - 1) / 4;
            exp_sel = 8'(1 << idx);
            if (dig_sel_a !== exp_sel) begin n_fail++; $display("FAIL post_reset_sel edge %0d: got %h expected %h", n, dig_sel_a, exp_sel); end
            n_checks++;
            if (seg_mux_a !== 7'h3F) begin n_fail++; $display("FAIL post_reset_seg edge %0d: got %h expected %h", n, seg_mux_a, 7'h3F); end
            n_checks++;
        end
    endtask

    task automatic test_mux_exit();
        mux_mode = 1'b0;
        step();
        if (dig_sel_a !== 8'h00 || seg_mux_a !== 7'h00) begin n_fail++; $display("FAIL mux_exit_a: got %h/%h expected 00/00", seg_mux_a, dig_sel_a); end
        n_checks++;
        if (dig_sel_b !== 8'hFF) begin n_fail++; $display("FAIL mux_exit_b: got %h expected ff", dig_sel_b); end
        n_checks++;
        if (dig_sel_c !== 1'b0) begin n_fail++; $display("FAIL mux_exit_c: got %h expected 0", dig_sel_c); end
        n_checks++;
        mux_mode = 1'b1;
        step();
        if (dig_sel_a !== 8'h01) begin n_fail++; $display("FAIL mux_reenter: got %h expected 01", dig_sel_a); end
        n_checks++;
        mux_mode = 1'b0;
    endtask

    initial begin
        seg_tbl[0]  = 7'h3F; seg_tbl[1]  = 7'h06; seg_tbl[2]  = 7'h5B; seg_tbl[3]  = 7'h4F;
        seg_tbl[4]  = 7'h66; seg_tbl[5]  = 7'h6D; seg_tbl[6]  = 7'h7D; seg_tbl[7]  = 7'h07;
        seg_tbl[8]  = 7'h7F; seg_tbl[9]  = 7'h6F; seg_tbl[10] = 7'h77; seg_tbl[11] = 7'h7C;
        seg_tbl[12] = 7'h39; seg_tbl[13] = 7'h5E; seg_tbl[14] = 7'h79; seg_tbl[15] = 7'h71;
        reset_in   = 1'b1;
        value      = 32'h0;
        load       = 1'b0;
        blink_mask = 8'h00;
        blank_lz   = 1'b0;
        mux_mode   = 1'b0;

        test_reset();
        test_load();
        test_active_low();
        test_back_to_back();
        test_blink();
        test_mux();
        test_reset_mid_dwell();
        test_mux_exit();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised seven-segment display controller. It is the registered, multi-digit successor to the fixed 4-digit hex LUT driver on the board top levels. It latches a hex value on a load strobe and applies leading-zero suppression and per-digit blinking. It drives either one static segment bus per digit or a single time-multiplexed segment bus with digit selects, so one block serves both the DE-series boards and scanned external displays.

## Interface
Parameters:
- DIGITS, 8, number of hex digits (1..16)
- SCAN_BITS, 16, prescaler width; mux mode dwells 2^SCAN_BITS clocks per digit
- BLINK_BITS, 24, free-running blink counter width; blink phase = counter MSB
- ACTIVE_LOW, 1, 1 = segments and digit selects are driven low-true

Ports:
- clk  in  1  system clock; the only clock
- reset_in  in  1  synchronous, active-high reset
- value  in  4*DIGITS  hex value; digit 0 = bits [3:0]
- load  in  1  capture value on this cycle
- blink_mask  in  DIGITS  1 = digit blinks
- blank_lz  in  1  1 = suppress leading zeros
- mux_mode  in  1  0 = static outputs, 1 = multiplexed outputs
- seg_static  out  7*DIGITS  per-digit segments {g,f,e,d,c,b,a}; digit i = bits [7i+6:7i]
- seg_mux  out  7  multiplexed segment bus
- dig_sel  out  DIGITS  one-hot digit enable, mux mode only

## Operation
- Held register: 4*DIGITS bits. Loaded from value on any edge where load=1; otherwise holds. The inputs blink_mask, blank_lz and mux_mode are used live and are not latched.
- Encoding, active-high form with a = bit 0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Blank = 00. When ACTIVE_LOW=1, the final bus is inverted, including blank.
- Leading-zero suppression, when blank_lz=1:
  - Digit i (i≥1) is blanked if it and every digit above it hold 0.
  - Digit 0 is never suppressed, so a held value of 0 shows a single "0".
- Blink:
  - The blink counter is BLINK_BITS wide, free-running, and wraps to 0.
  - While its MSB=1, every digit with blink_mask[i]=1 is blanked.
  - Blink and suppression combine by OR: a digit is blank if either condition applies.
- Static mode (mux_mode=0):
  - seg_static carries all digits.
  - seg_mux is blank and dig_sel is all inactive.
  - The prescaler and the scan index are held at 0.
- Mux mode (mux_mode=1):
  - The prescaler counts every clock.
  - At terminal count (all ones) the prescaler wraps, and the scan index advances 0→1→…→DIGITS-1→0.
  - seg_mux carries the digit at the scan index. dig_sel has only bit [index] active.
  - seg_static continues to be driven in mux mode as well.
- DIGITS=1: the scan index stays at 0 and dig_sel is permanently active in mux mode.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- Load latency:
  - load=1 is sampled at edge k and the held register updates at edge k.
  - seg_static and seg_mux reflect the new value after edge k+1.
- A second load at edge k+1 overrides the first; the display shows the first value for one cycle only.
- blink_mask, blank_lz and mux_mode take effect one edge after they change.
- Mux-mode dwell:
  - Each digit is displayed for exactly 2^SCAN_BITS clocks.
  - Going from mux_mode 0→1, digit 0 is shown first, for a full dwell.
  - Going from 1→0, the counters clear on the next edge and the mux outputs go inactive on the same edge.
- Reset, on any edge where reset_in=1:
  - The held register, prescaler, scan index and blink counter all go to 0.
  - seg_static, seg_mux and dig_sel go to all-blank/inactive: 0 if ACTIVE_LOW=0, all ones if ACTIVE_LOW=1.
  - Reset overrides load when both are asserted in the same cycle.
  - Normal display of the held value 0 resumes on the first edge after reset is released.
- Reset asserted mid-dwell or mid-blink restarts both counters from 0.

## Test plan
- Reset, then load value=32'h0000_00A5 with blank_lz=0, ACTIVE_LOW=0:
  - At k+1, seg_static digit 0 = 6D and digit 1 = 77.
  - Digits 2..7 = 3F.
- Same value with blank_lz=1:
  - Digits 2..7 = 00; digits 0 and 1 are unchanged.
  - Then load 0: digit 0 = 3F and all other digits = 00.
- ACTIVE_LOW=1, load 32'h8888_8888:
  - Every digit = 00 (all segments on), since 7F inverts to 00.
  - During reset, all outputs read all ones.
- blink_mask=8'h01, BLINK_BITS=4, value=1:
  - Digit 0 alternates 06 / 00 every 8 clocks.
  - The other digits hold steady.
- mux_mode=1, SCAN_BITS=2, DIGITS=8, value=32'h7654_3210:
  - dig_sel walks 01→02→…→80→01, changing every 4 clocks.
  - seg_mux = 3F, 06, 5B, … in step with dig_sel.
- Load and reset asserted on the same edge:
  - The held register stays 0.
  - Asserting reset mid-dwell in mux mode returns dig_sel to digit 0 with a full dwell after release.
